freq_counter: RTL and testbench
===============================

FREQ_COUNTER -- requirements
Module: freq_counter

Interface
REQ-001 Parameter GATE_CYCLES, default 1024: measurement window length in clock cycles, legal range 2..65535.
REQ-002 Parameter CNT_W, default 16: width of the edge count result.
REQ-003 Port clock, input, 1: sole clock; all state SHALL be clocked on its rising edge.
REQ-004 Port Reset, input, 1: asynchronous, active-low reset.
REQ-005 Port OscIn, input, 1: oscillator output under measurement; asynchronous to clock.
REQ-006 Port Start, input, 1: request one measurement; sampled only in IDLE.
REQ-007 Port Abort, input, 1: cancel a measurement in progress.
REQ-008 Port Count, output, CNT_W: rising-edge count of the last completed window.
REQ-009 Port Done, output, 1: one-cycle pulse when Count has been updated.
REQ-010 Port Busy, output, 1: high whenever the FSM is not in IDLE.
REQ-011 Port Overflow, output, 1: sticky flag set when the last window saturated.

Function
REQ-012 OscIn SHALL pass through a 2-flop synchronizer; a rising edge SHALL be flagged when the 2nd stage is 1 and its previous-cycle value was 0.
REQ-013 FSM states SHALL be IDLE, MEASURE and DONE.
REQ-014 IDLE: Start=1 and Abort=0 -> MEASURE next cycle; gate counter loaded with GATE_CYCLES-1; edge counter cleared; Overflow cleared.
REQ-015 MEASURE: gate counter SHALL decrement once per cycle; each flagged edge SHALL increment the edge counter in that cycle.
REQ-016 MEASURE lasts exactly GATE_CYCLES cycles; on the cycle the gate counter is 0 the FSM SHALL go to DONE, and an edge flagged in that final cycle SHALL be counted.
REQ-017 On entry to DONE, Count SHALL load the final edge count; Done SHALL be 1 for exactly that one cycle; the FSM SHALL then go to IDLE.
REQ-018 The edge counter SHALL saturate at 2^CNT_W-1; a flagged edge while saturated SHALL set Overflow, which holds until the next accepted Start or Reset.
REQ-019 Start while Busy=1 SHALL be ignored; it is not queued.
REQ-020 Abort=1 in MEASURE SHALL return to IDLE next cycle with no Done pulse; Count and Overflow keep their pre-Start values.
REQ-021 Start and Abort both high in IDLE: Abort wins and the FSM stays in IDLE.
REQ-022 Abort in DONE SHALL be ignored.
REQ-023 Count SHALL hold its value between completed windows.
REQ-024 Start-to-Done latency SHALL be GATE_CYCLES+1 cycles.

Reset
REQ-025 Reset low SHALL immediately force: state IDLE; Count=0, Done=0, Busy=0, Overflow=0; gate counter, edge counter and synchronizer flops all 0.
REQ-026 Reset asserted mid-measurement SHALL discard the window without a Done pulse; the first Start after release SHALL be accepted normally.

Structure
REQ-027 Package freq_counter_pkg SHALL hold the state enum (IDLE, MEASURE, DONE) and the default GATE_CYCLES and CNT_W constants.
REQ-028 The synchronizer and edge detector SHALL be a sub-module named sync_edge_detect, with ports clock, Reset, din and rise.
REQ-029 The gate counter width SHALL be $clog2(GATE_CYCLES).

Verification
REQ-030 GATE_CYCLES=16; OscIn period 4 clocks, 50% duty; one Start -> Done exactly 17 cycles after Start, Count=4, Overflow=0.
REQ-031 OscIn held at 0, then held at 1, for one window each -> Count=0 both times, Done pulses once per window.
REQ-032 CNT_W=3, GATE_CYCLES=32, OscIn period 2 clocks -> Count=7, Overflow=1; the next Start clears Overflow.
REQ-033 Complete one window with Count=4, then Start, then Abort 5 cycles later -> Busy falls the next cycle, no Done, Count stays 4.
REQ-034 Start pulsed again 3 cycles into MEASURE -> ignored; exactly one Done at cycle 17. Start and Abort together in IDLE -> Busy stays 0.
REQ-035 Reset asserted at cycle 8 of MEASURE -> all outputs 0 immediately, no Done; a fresh Start gives the correct Count.

Source files
------------

// File: rtl/freq_counter_pkg.sv
// Shared types and defaults for the gated frequency counter.
package freq_counter_pkg;

  // Measurement sequencer states.
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    MEASURE = 2'd1,
    DONE    = 2'd2
  } state_t;

  // Default window length in clock cycles.
  localparam int DEF_GATE_CYCLES = 1024;

  // Default width of the edge count result.
  localparam int DEF_CNT_W = 16;

  // Number of flops in the oscillator synchronizer chain.
  localparam int SYNC_STAGES = 2;

endpackage

// File: rtl/sync_edge_detect.sv
// Brings the asynchronous oscillator into the clock domain through a flop
// chain, then flags a rising edge for one cycle when the last stage goes 0->1.
module sync_edge_detect
  import freq_counter_pkg::*;
(
  input  logic clock,
  input  logic Reset,
  input  logic din,
  output logic rise
);

  logic sync_reg [SYNC_STAGES];
  logic last_reg;

  genvar gi;
  generate
    for (gi = 0; gi < SYNC_STAGES; gi++) begin : g_sync
      if (gi == 0) begin : g_first
        // First stage samples the raw asynchronous input.
        always_ff @(posedge clock or negedge Reset) begin
          if (!Reset) sync_reg[gi] <= 1'b0;
          else        sync_reg[gi] <= din;
        end
      end else begin : g_next
        // Later stages give metastability time to resolve.
        always_ff @(posedge clock or negedge Reset) begin
          if (!Reset) sync_reg[gi] <= 1'b0;
          else        sync_reg[gi] <= sync_reg[gi-1];
        end
      end
    end
  endgenerate

  // Remember the previous value of the final stage for edge detection.
  always_ff @(posedge clock or negedge Reset) begin
    if (!Reset) last_reg <= 1'b0;
    else        last_reg <= sync_reg[SYNC_STAGES-1];
  end

  assign rise = sync_reg[SYNC_STAGES-1] & ~last_reg;

endmodule

// File: rtl/freq_counter.sv
// Counts rising edges of an asynchronous oscillator over a fixed window of
// GATE_CYCLES clocks. The result is published on Count with a one-cycle Done
// pulse; the edge counter saturates and raises a sticky Overflow flag.
module freq_counter
  import freq_counter_pkg::*;
#(
  parameter int GATE_CYCLES = DEF_GATE_CYCLES,
  parameter int CNT_W       = DEF_CNT_W
) (
  input  logic             clock,
  input  logic             Reset,
  input  logic             OscIn,
  input  logic             Start,
  input  logic             Abort,
  output logic [CNT_W-1:0] Count,
  output logic             Done,
  output logic             Busy,
  output logic             Overflow
);

  localparam int                GATE_W    = $clog2(GATE_CYCLES);
  localparam logic [GATE_W-1:0] GATE_LOAD = GATE_W'(GATE_CYCLES - 1);
  localparam logic [CNT_W-1:0]  CNT_MAX   = '1;

  state_t              state_reg, state_next;
  logic [GATE_W-1:0]   gate_reg, gate_next;
  logic [CNT_W-1:0]    edge_reg, edge_next;
  logic [CNT_W-1:0]    count_reg, count_next;
  logic                ovf_reg, ovf_next;
  // Overflow as it stood before the current window started, so an aborted
  // window can leave the published flag exactly as it was before Start.
  logic                ovf_saved_reg, ovf_saved_next;
  logic                rise;

  sync_edge_detect u_sync (
    .clock (clock),
    .Reset (Reset),
    .din   (OscIn),
    .rise  (rise)
  );

  // Next-state and datapath update for the IDLE/MEASURE/DONE sequence.
  always_comb begin
    state_next     = state_reg;
    gate_next      = gate_reg;
    edge_next      = edge_reg;
    count_next     = count_reg;
    ovf_next       = ovf_reg;
    ovf_saved_next = ovf_saved_reg;

    case (state_reg)
      IDLE: begin
        // Abort has priority over Start while idle.
        if (Start && !Abort) begin
          state_next     = MEASURE;
          gate_next      = GATE_LOAD;
          edge_next      = '0;
          ovf_saved_next = ovf_reg;
          ovf_next       = 1'b0;
        end
      end

      MEASURE: begin
        if (Abort) begin
          state_next = IDLE;
          ovf_next   = ovf_saved_reg;
        end else begin
          if (rise) begin
            if (edge_reg == CNT_MAX) ovf_next  = 1'b1;
            else                     edge_next = edge_reg + CNT_W'(1);
          end
          if (gate_reg == '0) begin
            // Final window cycle: an edge seen now is included in the result.
            state_next = DONE;
            count_next = edge_next;
          end else begin
            gate_next = gate_reg - GATE_W'(1);
          end
        end
      end

      DONE: begin
        // Abort is ignored here; the result is already committed.
        state_next = IDLE;
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clock or negedge Reset) begin
    if (!Reset) begin
      state_reg     <= IDLE;
      gate_reg      <= '0;
      edge_reg      <= '0;
      count_reg     <= '0;
      ovf_reg       <= 1'b0;
      ovf_saved_reg <= 1'b0;
    end else begin
      state_reg     <= state_next;
      gate_reg      <= gate_next;
      edge_reg      <= edge_next;
      count_reg     <= count_next;
      ovf_reg       <= ovf_next;
      ovf_saved_reg <= ovf_saved_next;
    end
  end

  assign Count    = count_reg;
  assign Done     = (state_reg == DONE);
  assign Busy     = (state_reg != IDLE);
  assign Overflow = ovf_reg;

endmodule

// File: tb/tb_freq_counter.sv
// Bench for freq_counter: two instances (16-cycle window / 16-bit count and
// 32-cycle window / 3-bit count) checked every cycle against a window model,
// plus directed scenarios with hand-computed results.
module tb_freq_counter;

  localparam int G0   = 16;
  localparam int W0   = 16;
  localparam int MAX0 = 65535;
  localparam int G1   = 32;
  localparam int W1   = 3;
  localparam int MAX1 = 7;

  logic          clock;
  logic          Reset;
  logic          osc_v   [2];
  logic          start_v [2];
  logic          abort_v [2];
  logic          done_v  [2];
  logic          busy_v  [2];
  logic          ovf_v   [2];
  logic [W0-1:0] count0;
  logic [W1-1:0] count1;

  int total = 0;
  int bad   = 0;
  int pulses [2];
  int per_v  [2];
  int lvl_v  [2];
  int ph_v   [2];

  freq_counter #(.GATE_CYCLES(G0), .CNT_W(W0)) dut0 (
    .clock(clock), .Reset(Reset), .OscIn(osc_v[0]), .Start(start_v[0]),
    .Abort(abort_v[0]), .Count(count0), .Done(done_v[0]), .Busy(busy_v[0]),
    .Overflow(ovf_v[0])
  );

  freq_counter #(.GATE_CYCLES(G1), .CNT_W(W1)) dut1 (
    .clock(clock), .Reset(Reset), .OscIn(osc_v[1]), .Start(start_v[1]),
    .Abort(abort_v[1]), .Count(count1), .Done(done_v[1]), .Busy(busy_v[1]),
    .Overflow(ovf_v[1])
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // Window model: an accepted Start opens a window of G edges; edges of the
  // oscillator are seen two clocks late; the result is the saturated count.
  typedef struct {
    bit       act;    // window in progress or result cycle pending
    int       pos;    // clock edges since the accepted Start
    int       raw;    // unsaturated edges seen in this window
    int       cnt;    // published result
    bit       ovf;    // published overflow flag
    bit       saved;  // overflow flag before the current Start
    bit [2:0] s;      // recent oscillator samples, s[0] newest
  } mstate_t;

  mstate_t m [2];

  function automatic mstate_t step(mstate_t cur, int g, int mx, bit st, bit ab, bit osc);
    mstate_t n = cur;
    bit r;
    r = cur.s[1] & ~cur.s[2];
    if (cur.act) begin
      n.pos = cur.pos + 1;
      if (n.pos <= g) begin
        if (ab) begin
          n.act = 1'b0;
          n.ovf = cur.saved;
        end else begin
          if (r) n.raw = cur.raw + 1;
          n.ovf = (n.raw > mx);
          if (n.pos == g) n.cnt = (n.raw > mx) ? mx : n.raw;
        end
      end else begin
        n.act = 1'b0;
      end
    end else if (st && !ab) begin
      n.act   = 1'b1;
      n.pos   = 0;
      n.raw   = 0;
      n.saved = cur.ovf;
      n.ovf   = 1'b0;
    end
    n.s = {cur.s[1:0], osc};
    return n;
  endfunction

  always @(posedge clock or negedge Reset) begin
    if (!Reset) begin
      m[0] <= '{default: 0};
      m[1] <= '{default: 0};
    end else begin
      m[0] <= step(m[0], G0, MAX0, start_v[0], abort_v[0], osc_v[0]);
      m[1] <= step(m[1], G1, MAX1, start_v[1], abort_v[1], osc_v[1]);
    end
  end

  function automatic int gate_of(int d);
    return (d == 0) ? G0 : G1;
  endfunction

  function automatic int cnt_of(int d);
    return (d == 0) ? int'(count0) : int'(count1);
  endfunction

  task automatic check(string name, int act, int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d, want %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick(int n = 1);
    repeat (n) begin
      @(negedge clock);
      #1;
    end
  endtask

  // Run one full window on instance d and check result, latency and pulses.
  task automatic run_window(int d, int exp_cnt, int exp_ovf, bit restart, string tag);
    int lat;
    int p0;
    p0 = pulses[d];
    start_v[d] = 1'b1;
    tick();
    start_v[d] = 1'b0;
    lat = 1;
    while (!done_v[d] && lat < 200) begin
      start_v[d] = restart && (lat == 3);
      tick();
      lat++;
    end
    start_v[d] = 1'b0;
    check({tag, "_latency"}, lat, gate_of(d) + 1);
    check({tag, "_count"}, cnt_of(d), exp_cnt);
    check({tag, "_ovf"}, int'(ovf_v[d]), exp_ovf);
    tick();
    check({tag, "_pulses"}, pulses[d] - p0, 1);
    $display("window %s: dut%0d count=%0d ovf=%0d latency=%0d", tag, d, cnt_of(d), ovf_v[d], lat);
  endtask

  initial begin
    int p0;
    Reset      = 1'b0;
    osc_v[0]   = 1'b0; osc_v[1]   = 1'b0;
    start_v[0] = 1'b0; start_v[1] = 1'b0;
    abort_v[0] = 1'b0; abort_v[1] = 1'b0;
    pulses[0]  = 0;    pulses[1]  = 0;
    per_v[0]   = 0;    per_v[1]   = 0;
    lvl_v[0]   = 0;    lvl_v[1]   = 0;
    ph_v[0]    = 0;    ph_v[1]    = 0;

    fork
      // Oscillator stimulus: fixed level or square wave of period per_v.
      forever begin
        @(negedge clock);
        #1;
        for (int d = 0; d < 2; d++) begin
          if (per_v[d] == 0) begin
            osc_v[d] = (lvl_v[d] != 0);
          end else begin
            osc_v[d] = (ph_v[d] < per_v[d] / 2);
            ph_v[d]  = (ph_v[d] + 1) % per_v[d];
          end
        end
      end
      // Per-cycle comparison against the window model.
      forever begin
        @(negedge clock);
        for (int d = 0; d < 2; d++) begin
          check($sformatf("cyc_busy%0d", d), int'(busy_v[d]), int'(m[d].act));
          check($sformatf("cyc_done%0d", d), int'(done_v[d]),
                int'(m[d].act && (m[d].pos == gate_of(d))));
          check($sformatf("cyc_count%0d", d), cnt_of(d), m[d].cnt);
          check($sformatf("cyc_ovf%0d", d), int'(ovf_v[d]), int'(m[d].ovf));
          if (done_v[d] === 1'b1) pulses[d]++;
        end
      end
    join_none

    // Reset state.
    #1;
    check("rst_busy", int'(busy_v[0]), 0);
    check("rst_done", int'(done_v[0]), 0);
    check("rst_count", cnt_of(0), 0);
    check("rst_ovf", int'(ovf_v[0]), 0);
    tick(3);
    Reset = 1'b1;
    tick(3);

    // Period-4 oscillator over a 16-cycle window: four edges.
    per_v[0] = 4;
    tick(4);
    run_window(0, 4, 0, 1'b0, "p4");

    // Constant low, then constant high: no edges in either window.
    per_v[0] = 0;
    lvl_v[0] = 0;
    tick(4);
    run_window(0, 0, 0, 1'b0, "low");
    lvl_v[0] = 1;
    tick(4);
    run_window(0, 0, 0, 1'b0, "high");

    // Abort five cycles after Start: no Done, Count keeps the old result.
    per_v[0] = 4;
    tick(4);
    run_window(0, 4, 0, 1'b0, "pre_abort");
    p0 = pulses[0];
    start_v[0] = 1'b1;
    tick();
    start_v[0] = 1'b0;
    tick(4);
    check("abort_busy_before", int'(busy_v[0]), 1);
    abort_v[0] = 1'b1;
    tick();
    abort_v[0] = 1'b0;
    check("abort_busy_after", int'(busy_v[0]), 0);
    check("abort_count", cnt_of(0), 4);
    tick(25);
    check("abort_no_done", pulses[0] - p0, 0);
    check("abort_count_hold", cnt_of(0), 4);
    $display("abort: busy=%0d count=%0d pulses=%0d", busy_v[0], cnt_of(0), pulses[0] - p0);

    // Second Start during MEASURE is ignored; exactly one Done.
    run_window(0, 4, 0, 1'b1, "restart");
    tick(20);
    check("restart_no_extra", pulses[0], p0 + 1);

    // Start and Abort together in IDLE: stays idle.
    start_v[0] = 1'b1;
    abort_v[0] = 1'b1;
    tick();
    start_v[0] = 1'b0;
    abort_v[0] = 1'b0;
    check("both_busy", int'(busy_v[0]), 0);
    tick(3);
    check("both_busy_later", int'(busy_v[0]), 0);
    $display("start+abort in idle: busy=%0d", busy_v[0]);

    // Reset in the middle of a window.
    p0 = pulses[0];
    start_v[0] = 1'b1;
    tick();
    start_v[0] = 1'b0;
    tick(7);
    check("midrst_busy_before", int'(busy_v[0]), 1);
    Reset = 1'b0;
    #1;
    check("midrst_busy", int'(busy_v[0]), 0);
    check("midrst_done", int'(done_v[0]), 0);
    check("midrst_count", cnt_of(0), 0);
    check("midrst_ovf", int'(ovf_v[0]), 0);
    $display("reset mid-window: busy=%0d count=%0d", busy_v[0], cnt_of(0));
    tick(4);
    Reset = 1'b1;
    tick(4);
    check("midrst_no_done", pulses[0] - p0, 0);
    run_window(0, 4, 0, 1'b0, "after_rst");

    // 3-bit counter, 32-cycle window, period-2 oscillator: saturates.
    per_v[1] = 2;
    tick(4);
    run_window(1, 7, 1, 1'b0, "sat");
    per_v[1] = 0;
    lvl_v[1] = 0;
    tick(4);
    check("sat_ovf_sticky", int'(ovf_v[1]), 1);
    check("sat_count_hold", cnt_of(1), 7);
    run_window(1, 0, 0, 1'b0, "sat_clear");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
